// File: rtl/alu_cmd_queue.sv
// Command queue in front of an 8-bit ALU: FIFO of {op, a, b}, illegal op 3'b111 dropped and counted.
// Optional same-cycle bypass from an empty queue when ALU_CMD_QUEUE_BYPASS_EN is defined.
module alu_cmd_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               in_op,
    input  logic [7:0]               in_a,
    input  logic [7:0]               in_b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [2:0]               out_op,
    output logic [7:0]               out_a,
    output logic [7:0]               out_b,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     illegal_op,
    output logic [7:0]               drop_cnt
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [2:0] OP_ILLEGAL = 3'b111;

    typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} state_e;

    state_e          state_q;
    logic [2:0]      op_q [DEPTH];
    logic [7:0]      a_q  [DEPTH];
    logic [7:0]      b_q  [DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q, count_d;
    logic            illegal_q;
    logic [7:0]      drop_q;

    logic accept, legal, drop, push, pop, head_valid;

    assign in_ready   = (state_q != FULL);
    assign head_valid = (state_q != EMPTY);
    assign accept     = in_valid && in_ready;
    assign legal      = (in_op != OP_ILLEGAL);
    assign drop       = accept && !legal;
    assign pop        = head_valid && out_ready;

`ifdef ALU_CMD_QUEUE_BYPASS_EN
    logic bypass;
    // An empty queue forwards a legal command straight through; it is stored only if the ALU stalls.
    assign bypass    = (state_q == EMPTY) && in_valid && legal;
    assign out_valid = head_valid || bypass;
    assign out_op    = bypass ? in_op : op_q[rd_ptr_q];
    assign out_a     = bypass ? in_a  : a_q[rd_ptr_q];
    assign out_b     = bypass ? in_b  : b_q[rd_ptr_q];
    assign push      = accept && legal && !(bypass && out_ready);
`else
    assign out_valid = head_valid;
    assign out_op    = op_q[rd_ptr_q];
    assign out_a     = a_q[rd_ptr_q];
    assign out_b     = b_q[rd_ptr_q];
    assign push      = accept && legal;
`endif

    assign count      = count_q;
    assign illegal_op = illegal_q;
    assign drop_cnt   = drop_q;

    always_comb begin
        count_d = count_q;
        if (push && !pop)
            count_d = count_q + CW'(1);
        else if (pop && !push)
            count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= EMPTY;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            illegal_q <= 1'b0;
            drop_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                op_q[i] <= '0;
                a_q[i]  <= '0;
                b_q[i]  <= '0;
            end
        end else begin
            count_q   <= count_d;
            illegal_q <= drop;
            if (drop && drop_q != 8'hFF)
                drop_q <= drop_q + 8'd1;
            if (push) begin
                op_q[wr_ptr_q] <= in_op;
                a_q[wr_ptr_q]  <= in_a;
                b_q[wr_ptr_q]  <= in_b;
                wr_ptr_q       <= wr_ptr_q + PW'(1);
            end
            if (pop)
                rd_ptr_q <= rd_ptr_q + PW'(1);
            // FULL never pushes, EMPTY never pops from storage.
            case (state_q)
                EMPTY:   if (push) state_q <= PARTIAL;
                PARTIAL: begin
                    if (push && !pop && count_q == DEPTH_C - CW'(1))
                        state_q <= FULL;
                    else if (pop && !push && count_q == CW'(1))
                        state_q <= EMPTY;
                end
                FULL:    if (pop) state_q <= PARTIAL;
                default: state_q <= EMPTY;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_cmd_queue.sv
// Self-checking bench for alu_cmd_queue: directed scenarios plus randomized traffic against a queue model.
module tb_alu_cmd_queue;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready;
    logic [2:0] in_op;
    logic [7:0] in_a, in_b;
    logic       out_valid, out_ready;
    logic [2:0] out_op;
    logic [7:0] out_a, out_b;
    logic [$clog2(DEPTH):0] count;
    logic       illegal_op;
    logic [7:0] drop_cnt;

    int total = 0;
    int pass  = 0;

    logic [18:0] mq[$];
    logic        m_illegal = 1'b0;
    int          m_drop = 0;

    alu_cmd_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op(out_op), .out_a(out_a), .out_b(out_b),
        .count(count), .illegal_op(illegal_op), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic set_in(input logic v, input logic [2:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic r);
        in_valid  = v;
        in_op     = op;
        in_a      = a;
        in_b      = b;
        out_ready = r;
    endtask

    // Advances the reference queue by one clock from the inputs currently applied.
    task automatic tick();
        int   sz    = mq.size();
        logic legal = (in_op != 3'b111);
        logic acc   = in_valid && (sz != DEPTH);
        logic byp   = 1'b0;
`ifdef ALU_CMD_QUEUE_BYPASS_EN
        byp = (sz == 0) && in_valid && legal;
`endif
        if (sz != 0 && out_ready) void'(mq.pop_front());
        if (acc && legal && !(byp && out_ready)) mq.push_back({in_op, in_a, in_b});
        m_illegal = acc && !legal;
        if (m_illegal && m_drop != 255) m_drop++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_in(1'b0, 3'd0, 8'd0, 8'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        total++; if (count !== 0) $display("FAIL reset_count: got %0d expected 0", count); else pass++;
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else pass++;
        total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready); else pass++;
        total++; if ({out_op, out_a, out_b} !== 19'd0) $display("FAIL reset_head: got %h expected 0", {out_op, out_a, out_b}); else pass++;
        total++; if (illegal_op !== 1'b0 || drop_cnt !== 8'd0)
            $display("FAIL reset_drop: got illegal=%b drop=%0d expected 0/0", illegal_op, drop_cnt); else pass++;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
`ifdef ALU_CMD_QUEUE_BYPASS_EN
        set_in(1'b1, 3'b000, 8'h05, 8'h03, 1'b0);
`else
        set_in(1'b1, 3'b000, 8'h05, 8'h03, 1'b1);
`endif
        tick();
        set_in(1'b0, 3'd0, 8'd0, 8'd0, 1'b1);
        #1;
        total++; if (out_valid !== 1'b1) $display("FAIL single_valid: got %b expected 1", out_valid); else pass++;
        total++; if ({out_op, out_a, out_b} !== {3'b000, 8'h05, 8'h03})
            $display("FAIL single_head: got %h expected %h", {out_op, out_a, out_b}, {3'b000, 8'h05, 8'h03}); else pass++;
        tick();
        total++; if (count !== 0) $display("FAIL single_count: got %0d expected 0", count); else pass++;
    endtask

    task automatic test_fill_order();
        for (int i = 1; i <= DEPTH; i++) begin
            set_in(1'b1, 3'($urandom_range(0, 6)), 8'(i), 8'($urandom), 1'b0);
            tick();
        end
        set_in(1'b1, 3'b001, 8'd5, 8'd5, 1'b0);
        #1;
        total++; if (count !== DEPTH) $display("FAIL fill_count: got %0d expected %0d", count, DEPTH); else pass++;
        total++; if (in_ready !== 1'b0) $display("FAIL fill_in_ready: got %b expected 0", in_ready); else pass++;
        tick();
        total++; if (count !== DEPTH || out_a !== 8'd1)
            $display("FAIL fill_fifth_held: got count=%0d a=%0d expected %0d/1", count, out_a, DEPTH); else pass++;
        for (int k = 1; k <= DEPTH; k++) begin
            set_in(1'b0, 3'd0, 8'd0, 8'd0, 1'b1);
            #1;
            total++; if (out_valid !== 1'b1 || out_a !== 8'(k))
                $display("FAIL fill_order: got valid=%b a=%0d expected 1/%0d", out_valid, out_a, k); else pass++;
            tick();
        end
        total++; if (count !== 0) $display("FAIL fill_drained: got %0d expected 0", count); else pass++;
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < DEPTH; i++) begin
            set_in(1'b1, 3'b010, 8'h20 + 8'(i), 8'h00, 1'b0);
            tick();
        end
        set_in(1'b1, 3'b011, 8'hAA, 8'hBB, 1'b1);
        tick();
        set_in(1'b0, 3'd0, 8'd0, 8'd0, 1'b0);
        #1;
        total++; if (count !== DEPTH - 1) $display("FAIL full_pop_count: got %0d expected %0d", count, DEPTH - 1); else pass++;
        total++; if (in_ready !== 1'b1) $display("FAIL full_pop_ready: got %b expected 1", in_ready); else pass++;
        total++; if (out_a !== 8'h21) $display("FAIL full_pop_head: got %h expected 21", out_a); else pass++;
        set_in(1'b0, 3'd0, 8'd0, 8'd0, 1'b1);
        repeat (DEPTH - 1) tick();
        total++; if (count !== 0) $display("FAIL full_drain: got %0d expected 0", count); else pass++;
    endtask

    task automatic test_illegal();
        set_in(1'b1, 3'b111, 8'h12, 8'h34, 1'b1);
        #1;
        total++; if (out_valid !== 1'b0) $display("FAIL illegal_no_valid: got %b expected 0", out_valid); else pass++;
        tick();
        set_in(1'b0, 3'd0, 8'd0, 8'd0, 1'b1);
        #1;
        total++; if (illegal_op !== 1'b1 || drop_cnt !== 8'd1)
            $display("FAIL illegal_pulse: got illegal=%b drop=%0d expected 1/1", illegal_op, drop_cnt); else pass++;
        total++; if (count !== 0 || out_valid !== 1'b0)
            $display("FAIL illegal_not_stored: got count=%0d valid=%b expected 0/0", count, out_valid); else pass++;
        tick();
        total++; if (illegal_op !== 1'b0) $display("FAIL illegal_one_cycle: got %b expected 0", illegal_op); else pass++;
        set_in(1'b1, 3'b111, 8'h00, 8'h00, 1'b0);
        repeat (255) tick();
        total++; if (drop_cnt !== 8'd255) $display("FAIL drop_saturate: got %0d expected 255", drop_cnt); else pass++;
        set_in(1'b0, 3'd0, 8'd0, 8'd0, 1'b0);
        tick();
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 3'b100, 8'h40 + 8'(i), 8'h01, 1'b0);
            tick();
        end
        set_in(1'b0, 3'd0, 8'd0, 8'd0, 1'b0);
        #1;
        total++; if (count !== 3) $display("FAIL pre_reset_count: got %0d expected 3", count); else pass++;
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0 || count !== 0)
            $display("FAIL async_reset: got valid=%b count=%0d expected 0/0", out_valid, count); else pass++;
        total++; if (in_ready !== 1'b1 || drop_cnt !== 8'd0 || out_a !== 8'd0)
            $display("FAIL async_reset_outs: got ready=%b drop=%0d a=%h expected 1/0/00", in_ready, drop_cnt, out_a); else pass++;
        mq.delete();
        m_illegal = 1'b0;
        m_drop = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

`ifdef ALU_CMD_QUEUE_BYPASS_EN
    task automatic test_bypass();
        set_in(1'b1, 3'b001, 8'h10, 8'h01, 1'b1);
        #1;
        total++; if (out_valid !== 1'b1 || out_a !== 8'h10 || out_op !== 3'b001)
            $display("FAIL bypass_head: got valid=%b op=%0d a=%h expected 1/1/10", out_valid, out_op, out_a); else pass++;
        tick();
        set_in(1'b0, 3'd0, 8'd0, 8'd0, 1'b0);
        #1;
        total++; if (count !== 0) $display("FAIL bypass_count: got %0d expected 0", count); else pass++;
    endtask
`endif

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            logic [18:0] exp_head;
            logic        exp_v;
            set_in(1'($urandom_range(0, 99) < 60), 3'($urandom), 8'($urandom), 8'($urandom),
                   1'($urandom_range(0, 99) < 50));
            #1;
            exp_v    = (mq.size() != 0);
            exp_head = exp_v ? mq[0] : 19'd0;
`ifdef ALU_CMD_QUEUE_BYPASS_EN
            if (!exp_v && in_valid && in_op != 3'b111) begin
                exp_v    = 1'b1;
                exp_head = {in_op, in_a, in_b};
            end
`endif
            total++; if (int'(count) !== mq.size()) $display("FAIL rnd_count: got %0d expected %0d", count, mq.size()); else pass++;
            total++; if (in_ready !== (mq.size() != DEPTH)) $display("FAIL rnd_in_ready: got %b expected %b", in_ready, mq.size() != DEPTH); else pass++;
            total++; if (out_valid !== exp_v) $display("FAIL rnd_out_valid: got %b expected %b", out_valid, exp_v); else pass++;
            if (exp_v) begin
                total++; if ({out_op, out_a, out_b} !== exp_head)
                    $display("FAIL rnd_head: got %h expected %h", {out_op, out_a, out_b}, exp_head); else pass++;
            end
            total++; if (illegal_op !== m_illegal) $display("FAIL rnd_illegal: got %b expected %b", illegal_op, m_illegal); else pass++;
            total++; if (int'(drop_cnt) !== m_drop) $display("FAIL rnd_drop: got %0d expected %0d", drop_cnt, m_drop); else pass++;
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_order();
        test_full_push_pop();
        test_illegal();
        test_async_reset();
`ifdef ALU_CMD_QUEUE_BYPASS_EN
        test_bypass();
`endif
        test_random();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule

// File: doc/alu_cmd_queue.md
ALU_CMD_QUEUE -- requirements
Module: alu_cmd_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning command queue entries (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  upstream command valid.
REQ-005 SHALL have port in_ready  output  1  queue can accept a command.
REQ-006 SHALL have port in_op  input  3  ALU op code (000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR).
REQ-007 SHALL have port in_a  input  8  operand A.
REQ-008 SHALL have port in_b  input  8  operand B.
REQ-009 SHALL have port out_valid  output  1  head command presented to the ALU.
REQ-010 SHALL have port out_ready  input  1  ALU side consumes head command.
REQ-011 SHALL have port out_op  output  3  head op code, drives ALU op.
REQ-012 SHALL have port out_a  output  8  head operand A, drives ALU a.
REQ-013 SHALL have port out_b  output  8  head operand B, drives ALU b.
REQ-014 SHALL have port count  output  $clog2(DEPTH)+1  stored entries.
REQ-015 SHALL have port illegal_op  output  1  one-cycle pulse, illegal command dropped.
REQ-016 SHALL have port drop_cnt  output  8  saturating count of dropped commands.

Function
REQ-017 Input transfer SHALL occur on a cycle with in_valid && in_ready; output transfer on out_valid && out_ready.
REQ-018 in_ready SHALL equal (count != DEPTH); no combinational dependence on out_ready.
REQ-019 Queue SHALL be FIFO: out_op/out_a/out_b = entry at read pointer; out_valid = (count != 0).
REQ-020 Pointers SHALL wrap modulo DEPTH; count SHALL be the only full/empty discriminator.
REQ-021 FSM states SHALL be EMPTY (count 0), PARTIAL (0<count<DEPTH), FULL (count DEPTH); transitions driven by push-only (+1), pop-only (-1), push+pop or neither (hold).
REQ-022 Simultaneous push and pop in PARTIAL SHALL keep count unchanged and preserve order.
REQ-023 In FULL, push SHALL be refused (in_ready 0) even if out_ready is 1 that cycle; pop moves to PARTIAL next cycle.
REQ-024 Command with in_op 3'b111 SHALL be accepted (handshake completes, subject to in_ready) but not stored.
REQ-025 On such a drop illegal_op SHALL be 1 in the following cycle only; drop_cnt SHALL increment, saturating at 255.
REQ-026 Stored latency (no bypass): command pushed in cycle N SHALL appear with out_valid in cycle N+1 at earliest.
REQ-027 Head outputs SHALL hold stable while out_valid && !out_ready.

Reset
REQ-028 While rst_n low: count 0, pointers 0, storage 0, out_valid 0, out_op/out_a/out_b 0, in_ready 1, illegal_op 0, drop_cnt 0.
REQ-029 Reset asserted mid-operation SHALL discard all queued commands immediately (asynchronous).
REQ-030 First transfer after deassertion SHALL be accepted on the first rising edge with rst_n high.

Configuration
REQ-031 Macro ALU_CMD_QUEUE_BYPASS_EN SHALL, when defined, add same-cycle bypass: in EMPTY with a legal in_valid, out_valid=1 and out_* = in_* combinationally; if out_ready also 1 the command is not stored (count stays 0).
REQ-032 Without ALU_CMD_QUEUE_BYPASS_EN, out_* SHALL depend only on registered state; minimum latency one cycle (REQ-026).
REQ-033 Illegal op SHALL never be bypassed in either build.

Verification
REQ-034 Push ADD a=8'h05 b=8'h03, out_ready=1 -> next cycle out_valid=1, out_op=000, out_a=05, out_b=03; count returns 0 after pop.
REQ-035 out_ready=0, push DEPTH=4 commands (a=1..4) -> count=4, in_ready=0, 5th command held; then pop 4 -> out_a order 1,2,3,4.
REQ-036 In FULL, in_valid=1 and out_ready=1 same cycle -> pop only, count 3, in_ready 1 next cycle.
REQ-037 Push op=3'b111 -> no out_valid, illegal_op pulse one cycle, drop_cnt=1; 256 illegal pushes -> drop_cnt=255.
REQ-038 Queue at count 3, assert rst_n=0 mid-cycle -> out_valid 0, count 0 before next clock edge.
REQ-039 With ALU_CMD_QUEUE_BYPASS_EN, empty queue, push SUB a=8'h10 b=8'h01 with out_ready=1 -> out_valid=1 same cycle, out_a=10, count stays 0.
